// File: rtl/instr_dispatch_if.sv
// Host-side instruction push channel for instr_dispatch.
// Transfer happens on a rising edge with in_valid and in_ready both high.
interface instr_dispatch_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready
    );
endinterface

// File: rtl/instr_dispatch.sv
// Instruction FIFO feeding the datapath controller; the head is the IR,
// decoded combinationally and issued with an s/w start-done handshake.
module instr_dispatch #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    instr_dispatch_if.slave    host,
    input  logic               w,
    input  logic [1:0]         nsel,
    output logic               s,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [2:0]         readnum,
    output logic [2:0]         writenum,
    output logic [1:0]         shift,
    output logic [15:0]        sximm8,
    output logic [15:0]        sximm5,
    output logic               busy,
    output logic [COUNT_W-1:0] issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = host.in_valid & ~full;
    assign pop   = (state == BUSY) & w;

    assign host.in_ready = ~full;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            state        <= IDLE;
            issued_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                issued_count <= issued_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head is only popped at retire, so the IR holds through BUSY.
            case (state)
                IDLE:    if (!empty) state <= ISSUE;
                ISSUE:   if (w) state <= BUSY;
                BUSY:    if (w) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= host.in_instr;
    end

    assign head = empty ? 16'h0000 : mem[rd_ptr];

    assign opcode = head[15:13];
    assign op     = head[12:11];
    assign shift  = head[4:3];
    assign sximm8 = {{8{head[7]}}, head[7:0]};
    assign sximm5 = {{11{head[4]}}, head[4:0]};

    always_comb begin
        readnum = 3'b000;
        case (nsel)
            2'b00:   readnum = head[10:8];
            2'b01:   readnum = head[2:0];
            2'b10:   readnum = head[7:5];
            default: readnum = 3'b000;
        endcase
    end

    assign writenum = readnum;
    assign s        = (state == ISSUE);
    assign busy     = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_instr_dispatch.sv
// Randomized bench for instr_dispatch against a queue-based reference
// model of the dispatch rules, plus directed scenarios.
module tb_instr_dispatch;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = 4;
    localparam int CMOD    = 1 << COUNT_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               w;
    logic [1:0]         nsel;
    logic               s;
    logic [2:0]         opcode;
    logic [1:0]         op;
    logic [2:0]         readnum;
    logic [2:0]         writenum;
    logic [1:0]         shift;
    logic [15:0]        sximm8;
    logic [15:0]        sximm5;
    logic               busy;
    logic [COUNT_W-1:0] issued_count;

    instr_dispatch_if hif ();

    instr_dispatch #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (hif),
        .w            (w),
        .nsel         (nsel),
        .s            (s),
        .opcode       (opcode),
        .op           (op),
        .readnum      (readnum),
        .writenum     (writenum),
        .shift        (shift),
        .sximm8       (sximm8),
        .sximm5       (sximm5),
        .busy         (busy),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q[$];
    bit m_issue, m_exec;
    int m_total;
    bit pushed, retired_now;
    bit s_prev;
    int ctl_left;
    bit ctl_hold, w_hold;
    int stall_pct;
    bit wrap_on;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] hd, input int bits);
        int v;
        v = int'(hd) & ((1 << bits) - 1);
        if (v >= (1 << (bits - 1)))
            v = v - (1 << bits);
        return v[15:0];
    endfunction

    function automatic int rnum(input logic [15:0] hd, input logic [1:0] ns);
        case (ns)
            2'd0:    return (int'(hd) >> 8) & 7;
            2'd1:    return int'(hd) & 7;
            2'd2:    return (int'(hd) >> 5) & 7;
            default: return 0;
        endcase
    endfunction

    task automatic set_w(input bit v);
        w_hold = v;
        w = v;
    endtask

    task automatic cycle();
        bit acc, rst_e, iv;
        logic [15:0] din, hd;
        int sz;
        @(posedge clk);
        rst_e = reset;
        iv = hif.in_valid;
        din = hif.in_instr;
        acc = s_prev && w;
        pushed = 0;
        retired_now = 0;
        if (rst_e) begin
            q.delete();
            m_issue = 0;
            m_exec = 0;
            m_total = 0;
        end else begin
            sz = q.size();
            if (m_exec && w) begin
                void'(q.pop_front());
                m_exec = 0;
                m_total++;
                retired_now = 1;
            end else if (m_issue && w) begin
                m_issue = 0;
                m_exec = 1;
            end else if (!m_issue && !m_exec && sz > 0) begin
                m_issue = 1;
            end
            if (iv && sz < DEPTH) begin
                q.push_back(din);
                pushed = 1;
            end
        end
        #1;
        hd = (q.size() > 0) ? q[0] : 16'h0000;
        chk("s", 32'(s), 32'(m_issue));
        chk("busy", 32'(busy), 32'(m_issue || m_exec || q.size() > 0));
        chk("in_ready", 32'(hif.in_ready), 32'(q.size() < DEPTH));
        chk("issued_count", 32'(issued_count), 32'(m_total % CMOD));
        chk("opcode", 32'(opcode), (int'(hd) >> 13) & 7);
        chk("op", 32'(op), (int'(hd) >> 11) & 3);
        chk("shift", 32'(shift), (int'(hd) >> 3) & 3);
        chk("sximm8", 32'(sximm8), 32'(sx(hd, 8)));
        chk("sximm5", 32'(sximm5), 32'(sx(hd, 5)));
        chk("readnum", 32'(readnum), rnum(hd, nsel));
        chk("writenum", 32'(writenum), rnum(hd, nsel));
        if (wrap_on && retired_now) begin
            if (m_total == 15) chk("wrap15", 32'(issued_count), 32'd15);
            if (m_total == 16) chk("wrap16", 32'(issued_count), 32'd0);
            if (m_total == 17) chk("wrap17", 32'(issued_count), 32'd1);
        end
        s_prev = s;
        if (rst_e)
            ctl_left = 0;
        else if (acc)
            ctl_left = $urandom_range(1, 4);
        if (ctl_hold)
            w = w_hold;
        else if (ctl_left > 0) begin
            w = 1'b0;
            ctl_left--;
        end else
            w = ($urandom_range(0, 99) >= stall_pct);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        bit ok;
        ok = 0;
        hif.in_valid = 1'b1;
        hif.in_instr = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = pushed;
        end
        hif.in_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int n);
        bit done;
        done = 0;
        for (int i = 0; i < n && !done; i++) begin
            cycle();
            done = !m_issue && !m_exec && q.size() == 0;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [2:0] rn_exp [4];
        reset = 1'b1;
        w = 1'b1;
        nsel = 2'd0;
        hif.in_valid = 1'b0;
        hif.in_instr = 16'h0000;
        s_prev = 0;
        ctl_left = 0;
        ctl_hold = 0;
        w_hold = 0;
        stall_pct = 0;
        wrap_on = 0;
        m_issue = 0;
        m_exec = 0;
        m_total = 0;

        do_reset();
        do_reset();
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(hif.in_ready), 32'd1);
        chk("rst_count", 32'(issued_count), 32'd0);

        // Immediate move
        push_word(16'hD1FD);
        cycle();
        chk("mov_s", 32'(s), 32'd1);
        chk("mov_opcode", 32'(opcode), 32'd6);
        chk("mov_op", 32'(op), 32'd2);
        chk("mov_sximm8", 32'(sximm8), 32'hFFFD);
        chk("mov_readnum", 32'(readnum), 32'd1);
        chk("mov_writenum", 32'(writenum), 32'd1);
        wait_idle(50);
        chk("mov_count", 32'(issued_count), 32'd1);
        chk("mov_busy", 32'(busy), 32'd0);

        // ALU decode with nsel sweep
        rn_exp[0] = 3'd1;
        rn_exp[1] = 3'd0;
        rn_exp[2] = 3'd2;
        rn_exp[3] = 3'd0;
        push_word(16'hA148);
        cycle();
        chk("alu_s", 32'(s), 32'd1);
        chk("alu_opcode", 32'(opcode), 32'd5);
        chk("alu_op", 32'(op), 32'd0);
        chk("alu_shift", 32'(shift), 32'd1);
        chk("alu_sximm5", 32'(sximm5), 32'h0008);
        for (int i = 0; i < 4; i++) begin
            nsel = 2'(i);
            #1;
            chk("alu_readnum", 32'(readnum), 32'(rn_exp[i]));
        end
        nsel = 2'd0;
        wait_idle(50);

        // FIFO full with controller stalled
        ctl_hold = 1;
        set_w(1'b0);
        for (int i = 0; i < 4; i++)
            push_word(16'($urandom));
        hif.in_valid = 1'b1;
        hif.in_instr = 16'($urandom);
        for (int i = 0; i < 3; i++)
            cycle();
        chk("full_ready", 32'(hif.in_ready), 32'd0);
        chk("full_s", 32'(s), 32'd1);
        chk("full_held", 32'(pushed), 32'd0);
        ctl_hold = 0;
        push_word(hif.in_instr);
        wait_idle(200);

        // Reset while an instruction is in BUSY
        do_reset();
        ctl_hold = 1;
        set_w(1'b0);
        for (int i = 0; i < 3; i++)
            push_word(16'($urandom));
        set_w(1'b1);
        cycle();
        set_w(1'b0);
        cycle();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        hif.in_valid = 1'b1;
        hif.in_instr = 16'($urandom);
        cycle();
        reset = 1'b0;
        hif.in_valid = 1'b0;
        chk("mid_s", 32'(s), 32'd0);
        chk("mid_count", 32'(issued_count), 32'd0);
        chk("mid_ready", 32'(hif.in_ready), 32'd1);
        cycle();
        chk("mid_dropped", 32'(busy), 32'd0);
        ctl_hold = 0;

        // Counter wrap over 17 retirements
        do_reset();
        wrap_on = 1;
        stall_pct = 20;
        for (int i = 0; i < 17; i++)
            push_word(16'($urandom));
        wait_idle(400);
        chk("wrap_end", 32'(issued_count), 32'd1);
        chk("wrap_total", 32'(m_total), 32'd17);
        wrap_on = 0;

        // Random traffic
        stall_pct = 25;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            hif.in_valid = ($urandom_range(0, 2) == 0);
            hif.in_instr = 16'($urandom);
            nsel = 2'($urandom);
            cycle();
        end
        reset = 1'b0;
        hif.in_valid = 1'b0;
        wait_idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
